mu0_mem_arbiter: RTL and testbench

Shares the single-port 4K×16 memory between the MU0 core's memory port and a host loader/debug port. Each access is granted to one requester at a time, and the block sequences the memory control strobes over a configurable number of wait cycles. It returns read data and a completion pulse to the winning requester. It sits between the MU0 core (stalled on `cpu_done`) and the memory model.

---
 rtl/mu0_arb_pkg.sv | 25 ++
 rtl/mu0_arb_pick.sv | 33 +++
 rtl/mu0_mem_arbiter.sv | 110 +++++++++++
 tb/tb_mu0_mem_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mu0_arb_pkg.sv
// Shared types and constants for the MU0 memory arbiter.
package mu0_arb_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  // Access captured from the winning requester
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mu0_arb_pick.sv
// Combinational winner selection between the CPU and host ports.
// MU0_ARB_HOST_PRIORITY_EN selects fixed host priority instead of round-robin.
module mu0_arb_pick
  import mu0_arb_pkg::*;
(
  input  logic    cpu_req,
  input  logic    host_req,
  input  req_id_t owner,
  output req_id_t winner_c,
  output logic    any_c
);

`ifdef MU0_ARB_HOST_PRIORITY_EN
  logic unused_owner;
  assign unused_owner = owner;
`endif

  always_comb begin
    any_c    = cpu_req | host_req;
    winner_c = REQ_CPU;
    if (cpu_req && host_req) begin
`ifdef MU0_ARB_HOST_PRIORITY_EN
      winner_c = REQ_HOST;
`else
      // Tie goes to whoever did not win last
      winner_c = (owner == REQ_CPU) ? REQ_HOST : REQ_CPU;
`endif
    end else if (host_req) begin
      winner_c = REQ_HOST;
    end
  end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Arbitrates the single-port MU0 memory between the core and a host loader.
// Build option: MU0_ARB_HOST_PRIORITY_EN gives the host fixed priority on ties.
module mu0_mem_arbiter
  import mu0_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mu0_mem_arbiter: MEM_LATENCY must be 1..15");
  end

  arb_state_t       state;
  req_id_t          owner_q;
  logic [CNT_W-1:0] cnt;
  mem_cmd_t         cmd_q;
  req_id_t          winner_c;
  logic             any_c;

  mu0_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .host_req (host_req),
    .owner    (owner_q),
    .winner_c (winner_c),
    .any_c    (any_c)
  );

  // Memory address/data come straight from the captured command, so they hold between accesses
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign busy      = (state == ARB_ACCESS);
  assign owner     = (owner_q == REQ_HOST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner_q   <= REQ_HOST;
      cnt       <= '0;
      cmd_q     <= '0;
      rdata     <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      cpu_gnt   <= 1'b0;
      host_gnt  <= 1'b0;
      cpu_done  <= 1'b0;
      host_done <= 1'b0;
    end else begin
      cpu_gnt   <= 1'b0;
      host_gnt  <= 1'b0;
      cpu_done  <= 1'b0;
      host_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_c) begin
            if (winner_c == REQ_HOST) begin
              cmd_q    <= '{we: host_we, addr: host_addr, wdata: host_wdata};
              mem_rd   <= ~host_we;
              mem_wr   <= host_we;
              host_gnt <= 1'b1;
            end else begin
              cmd_q    <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
              mem_rd   <= ~cpu_we;
              mem_wr   <= cpu_we;
              cpu_gnt  <= 1'b1;
            end
            owner_q <= winner_c;
            cnt     <= CNT_W'(MEM_LATENCY - 1);
            state   <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            if (!cmd_q.we) rdata <= mem_rdata;
            cpu_done  <= (owner_q == REQ_CPU);
            host_done <= (owner_q == REQ_HOST);
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            state     <= ARB_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Randomized self-checking bench for mu0_mem_arbiter using a transaction-schedule model.
module tb_mu0_mem_arbiter;

  localparam int unsigned LAT = 3;

  logic        clk, rst;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [11:0] cpu_addr, host_addr, mem_addr;
  logic [15:0] cpu_wdata, host_wdata, rdata, mem_wdata, mem_rdata;
  logic        cpu_gnt, cpu_done, host_gnt, host_done;
  logic        mem_rd, mem_wr, busy, owner;

  mu0_mem_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_done(host_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT
  logic [15:0] mem [0:4095];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  // Reference model state
  typedef struct packed {
    bit        pend;
    bit        we;
    bit [11:0] addr;
    bit [15:0] wdata;
  } txn_t;

  logic [15:0] ref_mem [0:4095];
  txn_t        rq [2];
  int          t, free_at, start_at, done_at;
  bit          m_owner, cur_win, cur_we;
  bit [11:0]   cur_addr, exp_addr;
  bit [15:0]   cur_wdata, cur_rval, exp_wdata, exp_rdata;
  bit          exp_owner;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic check_cycle();
    bit act;
    if (t == start_at) begin
      exp_addr  = cur_addr;
      exp_wdata = cur_wdata;
      exp_owner = cur_win;
    end
    if (t == done_at && !cur_we) exp_rdata = cur_rval;
    act = (t >= start_at) && (t < done_at);
    chk("busy",      32'(busy),      32'(act));
    chk("mem_rd",    32'(mem_rd),    32'(act && !cur_we));
    chk("mem_wr",    32'(mem_wr),    32'(act && cur_we));
    chk("cpu_gnt",   32'(cpu_gnt),   32'(t == start_at && !cur_win));
    chk("host_gnt",  32'(host_gnt),  32'(t == start_at && cur_win));
    chk("cpu_done",  32'(cpu_done),  32'(t == done_at && !cur_win));
    chk("host_done", 32'(host_done), 32'(t == done_at && cur_win));
    chk("owner",     32'(owner),     32'(exp_owner));
    chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    chk("rdata",     32'(rdata),     32'(exp_rdata));
  endtask

  // mode 0: no new requests, 1: random requests, 2: both ports always requesting
  task automatic drive(input int mode);
    for (int i = 0; i < 2; i++) begin
      if (!rq[i].pend && (mode == 2 || (mode == 1 && $urandom_range(3) == 0))) begin
        rq[i].pend  = 1'b1;
        rq[i].we    = 1'($urandom_range(1));
        rq[i].addr  = ($urandom_range(7) == 0) ? 12'hFFF : 12'($urandom_range(15));
        rq[i].wdata = 16'($urandom);
      end
    end
    cpu_req  = rq[0].pend; cpu_we  = rq[0].we; cpu_addr  = rq[0].addr; cpu_wdata  = rq[0].wdata;
    host_req = rq[1].pend; host_we = rq[1].we; host_addr = rq[1].addr; host_wdata = rq[1].wdata;
  endtask

  // An idle cycle with pending requests starts an access lasting LAT cycles
  task automatic decide();
    bit win;
    if (t >= free_at && (rq[0].pend || rq[1].pend)) begin
      if (rq[0].pend && rq[1].pend) begin
`ifdef MU0_ARB_HOST_PRIORITY_EN
        win = 1'b1;
`else
        win = !m_owner;
`endif
      end else begin
        win = rq[1].pend;
      end
      cur_win   = win;
      cur_we    = rq[win].we;
      cur_addr  = rq[win].addr;
      cur_wdata = rq[win].wdata;
      if (cur_we) ref_mem[cur_addr] = cur_wdata;
      else        cur_rval = ref_mem[cur_addr];
      start_at  = t + 1;
      done_at   = t + int'(LAT) + 1;
      free_at   = done_at;
      m_owner   = win;
      rq[win].pend = 1'b0;
    end
  endtask

  task automatic step(input int mode);
    @(posedge clk);
    #1;
    t++;
    check_cycle();
    drive(mode);
    decide();
  endtask

  task automatic drain();
    repeat (3 * (LAT + 1) + 2) step(0);
  endtask

  initial begin
    total = 0; bad = 0;
    t = 0; free_at = 0; start_at = -100; done_at = -100;
    m_owner = 1'b1; exp_owner = 1'b1; cur_win = 1'b0; cur_we = 1'b0;
    cur_addr = '0; cur_wdata = '0; cur_rval = '0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    rq[0] = '0; rq[1] = '0;
    for (int a = 0; a < 4096; a++) begin
      mem[a]     = 16'($urandom);
      ref_mem[a] = mem[a];
    end
    rst = 1'b1;
    drive(0);
    repeat (2) @(posedge clk);
    #1;
    check_cycle();
    rst = 1'b0;
    repeat (2) step(0);

    // CPU read of a known word
    mem[5] = 16'h1234; ref_mem[5] = 16'h1234;
    rq[0] = '{pend: 1'b1, we: 1'b0, addr: 12'h005, wdata: 16'h0};
    drain();

    // Host write to the top address, then read it back
    rq[1] = '{pend: 1'b1, we: 1'b1, addr: 12'hFFF, wdata: 16'hBEEF};
    drain();
    rq[1] = '{pend: 1'b1, we: 1'b0, addr: 12'hFFF, wdata: 16'h0};
    drain();

    repeat (400) step(1);
    drain();

    // Both ports requesting continuously
    repeat (40) step(2);
    drain();

    // Reset during the second strobe cycle of a read
    rq[0] = '{pend: 1'b1, we: 1'b0, addr: 12'h005, wdata: 16'h0};
    repeat (3) step(0);
    #1 rst = 1'b1;
    #1;
    chk("rst_mem_rd",   32'(mem_rd),   32'd0);
    chk("rst_mem_wr",   32'(mem_wr),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_owner",    32'(owner),    32'd1);
    chk("rst_cpu_done", 32'(cpu_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    start_at = -100; done_at = -100; free_at = t;
    m_owner = 1'b1; exp_owner = 1'b1; cur_we = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    repeat (LAT + 2) step(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
